// File: rtl/seq_det_sched.sv
// ============================================================================
//  Module      : seq_det_sched
//  Description : Round-robin scheduler that grants one of four serial
//                requesters a whole frame and counts pattern matches in it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_det_sched #(
    parameter int N_REQ = 4,
    parameter int PAT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [PAT_W-1:0]         cfg_pattern,
    input  logic [3:0]               cfg_len,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         din,
    input  logic [N_REQ-1:0]         last,
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic                     hit,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic [7:0]               hit_cnt,
    output logic                     cfg_err
);

    localparam int ID_W = $clog2(N_REQ);
    localparam int NB_W = $clog2(PAT_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [PAT_W-1:0] PAT_RST = 8'b0001_1010;
    localparam logic [3:0]       LEN_RST = 4'd5;

    logic [1:0]       state_q,   state_d;
    logic [ID_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [ID_W-1:0]  id_q,      id_d;
    logic [PAT_W-1:0] sr_q,      sr_d;
    logic [NB_W-1:0]  nbits_q,   nbits_d;
    logic [7:0]       cnt_q,     cnt_d;
    logic [PAT_W-1:0] pat_q,     pat_d;
    logic [3:0]       len_q,     len_d;
    logic             hit_q,     hit_d;
    logic             cfg_err_q, cfg_err_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [7:0]       hit_cnt_q, hit_cnt_d;

    logic [ID_W-1:0]  w_win;
    logic             w_any;
    logic [3:0]       w_len_eff;
    logic [PAT_W-1:0] w_mask;
    logic [PAT_W-1:0] w_sr_shift;
    logic [NB_W-1:0]  w_nbits_inc;
    logic             w_match;
    logic             w_consume;
    logic [7:0]       w_cnt_next;

    // Round-robin search starting at rr_ptr; the 2-bit index wraps naturally.
    always_comb begin
        logic             found;
        logic [ID_W-1:0]  idx;
        found = 1'b0;
        w_win = rr_ptr_q;
        idx   = rr_ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            idx = rr_ptr_q + ID_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                w_win = idx;
            end
        end
    end

    assign w_any = |req;

    // Lengths beyond the shift register clamp to its width.
    assign w_len_eff = (len_q > 4'(PAT_W)) ? 4'(PAT_W) : len_q;

    always_comb begin
        w_mask = '0;
        for (int b = 0; b < PAT_W; b++) begin
            w_mask[b] = (NB_W'(b) < NB_W'(w_len_eff));
        end
    end

    assign w_consume   = (state_q == S_RUN) && req[id_q];
    assign w_sr_shift  = {sr_q[PAT_W-2:0], din[id_q]};
    assign w_nbits_inc = (nbits_q == NB_W'(PAT_W)) ? nbits_q : nbits_q + NB_W'(1);
    assign w_match     = (w_len_eff != 4'd0)
                      && (w_nbits_inc >= NB_W'(w_len_eff))
                      && (((w_sr_shift ^ pat_q) & w_mask) == '0);
    assign w_cnt_next  = (w_match && (cnt_q != 8'hFF)) ? cnt_q + 8'd1 : cnt_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        sr_d      = sr_q;
        nbits_d   = nbits_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        len_d     = len_q;
        hit_d     = 1'b0;
        cfg_err_d = 1'b0;
        done_id_d = done_id_q;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    len_d = cfg_len;
                end
                if (w_any) begin
                    state_d  = S_RUN;
                    id_d     = w_win;
                    rr_ptr_d = w_win + ID_W'(1);
                    sr_d     = '0;
                    nbits_d  = '0;
                    cnt_d    = '0;
                end
            end
            S_RUN: begin
                cfg_err_d = cfg_we;
                if (w_consume) begin
                    sr_d    = w_sr_shift;
                    nbits_d = w_nbits_inc;
                    hit_d   = w_match;
                    cnt_d   = w_cnt_next;
                    // Snapshot includes a match on the final bit.
                    if (last[id_q]) begin
                        state_d   = S_DONE;
                        done_id_d = id_q;
                        hit_cnt_d = w_cnt_next;
                    end
                end
            end
            S_DONE: begin
                cfg_err_d = cfg_we;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            sr_q      <= '0;
            nbits_q   <= '0;
            cnt_q     <= '0;
            pat_q     <= PAT_RST;
            len_q     <= LEN_RST;
            hit_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            done_id_q <= '0;
            hit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            sr_q      <= sr_d;
            nbits_q   <= nbits_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            hit_q     <= hit_d;
            cfg_err_q <= cfg_err_d;
            done_id_q <= done_id_d;
            hit_cnt_q <= hit_cnt_d;
        end
    end

    // Grant derives from registered state only, so reset removes it at once.
    always_comb begin
        gnt = '0;
        if (state_q == S_RUN) begin
            gnt[id_q] = 1'b1;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign hit     = hit_q;
    assign cfg_err = cfg_err_q;
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;

endmodule

`default_nettype wire
